// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the key store: key-length lookups, Rcon table and
// an arithmetic S-box (GF(2^8) inverse followed by the FIPS-197 affine map).
package aes_pkg;

    localparam int MAX_WORDS = 60;

    typedef enum logic [1:0] {
        KEY_128 = 2'd0,
        KEY_192 = 2'd1,
        KEY_256 = 2'd2
    } key_len_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2,
        ST_ZERO   = 2'd3
    } state_t;

    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [3:0] nk_of(input key_len_t len);
        case (len)
            KEY_192: return 4'd6;
            KEY_256: return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_t len);
        case (len)
            KEY_192: return 4'd12;
            KEY_256: return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] nw_of(input key_len_t len);
        case (len)
            KEY_192: return 6'd52;
            KEY_256: return 6'd60;
            default: return 6'd44;
        endcase
    endfunction

    function automatic logic [7:0] rcon_of(input logic [5:0] q);
        return ((q >= 6'd1) && (q <= 6'd10)) ? RCON[4'(q - 6'd1)] : 8'h00;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            p  = b[k] ? (p ^ aa) : p;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 0; k < 7; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_store_if.sv
// Control/read bus of the AES key store. Zeroize signals exist only with AES_KEY_ZEROIZE_EN.
interface aes_key_store_if #(
    parameter int NUM_SLOTS = 4
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic                 init_in;
    logic [SLOT_W-1:0]    init_slot_in;
    logic [1:0]           key_len_in;
    logic [255:0]         key_in;
    logic                 init_ready_out;
    logic                 key_expanded_out;
    logic [SLOT_W-1:0]    rd_slot_in;
    logic [3:0]           round_rd_in;
    logic [127:0]         key_out;
    logic                 key_valid_out;
    logic [NUM_SLOTS-1:0] slot_valid_out;
`ifdef AES_KEY_ZEROIZE_EN
    logic                 zeroize_in;
    logic [SLOT_W-1:0]    zeroize_slot_in;

    modport master (
        output init_in, init_slot_in, key_len_in, key_in, rd_slot_in, round_rd_in,
               zeroize_in, zeroize_slot_in,
        input  init_ready_out, key_expanded_out, key_out, key_valid_out, slot_valid_out
    );
    modport slave (
        input  init_in, init_slot_in, key_len_in, key_in, rd_slot_in, round_rd_in,
               zeroize_in, zeroize_slot_in,
        output init_ready_out, key_expanded_out, key_out, key_valid_out, slot_valid_out
    );
`else
    modport master (
        output init_in, init_slot_in, key_len_in, key_in, rd_slot_in, round_rd_in,
        input  init_ready_out, key_expanded_out, key_out, key_valid_out, slot_valid_out
    );
    modport slave (
        input  init_in, init_slot_in, key_len_in, key_in, rd_slot_in, round_rd_in,
        output init_ready_out, key_expanded_out, key_out, key_valid_out, slot_valid_out
    );
`endif
endinterface

// File: rtl/aes_key_word_step.sv
// One KeyExpansion step for i >= Nk: w[i] = w[i-Nk] ^ f(w[i-1]).
module aes_key_word_step
    import aes_pkg::*;
(
    input  logic [31:0] w_prev_i,
    input  logic [31:0] w_back_nk_i,
    input  logic [5:0]  idx_i,
    input  logic [3:0]  nk_i,
    output logic [31:0] w_next_o
);
    logic [5:0]  quot_s;
    logic [2:0]  rem_s;
    logic [31:0] f_s;

    // i / Nk and i mod Nk for the three legal Nk values
    always_comb begin
        case (nk_i)
            4'd6: begin
                quot_s = idx_i / 6'd6;
                rem_s  = 3'(idx_i % 6'd6);
            end
            4'd8: begin
                quot_s = {3'd0, idx_i[5:3]};
                rem_s  = idx_i[2:0];
            end
            default: begin
                quot_s = {2'd0, idx_i[5:2]};
                rem_s  = {1'b0, idx_i[1:0]};
            end
        endcase
    end

    // Word transform selected by position within the Nk-word group
    always_comb begin
        if (rem_s == 3'd0) begin
            f_s = sub_word(rot_word(w_prev_i)) ^ {rcon_of(quot_s), 24'd0};
        end else if ((nk_i == 4'd8) && (rem_s == 3'd4)) begin
            f_s = sub_word(w_prev_i);
        end else begin
            f_s = w_prev_i;
        end
    end

    assign w_next_o = w_back_nk_i ^ f_s;

endmodule

// File: rtl/aes_key_store.sv
// Multi-slot AES round-key store: expands keys one word per cycle into per-slot schedules and
// serves registered 128-bit round keys. AES_KEY_ZEROIZE_EN adds a per-slot wipe command.
module aes_key_store
    import aes_pkg::*;
#(
    parameter int NUM_SLOTS = 4
) (
    input  logic           clk_in,
    input  logic           rst_in,
    aes_key_store_if.slave bus
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    state_t               state_q, state_d;
    logic [5:0]           idx_q, idx_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    key_len_t             len_q, len_d;
    logic [7:0][31:0]     key_q, key_d;
    logic [7:0][31:0]     win_q, win_d;
    logic [NUM_SLOTS-1:0] slot_valid_q, slot_valid_d;
    key_len_t             slot_len_q [NUM_SLOTS];
    key_len_t             slot_len_d [NUM_SLOTS];
    logic [31:0]          mem_q [NUM_SLOTS][MAX_WORDS];
    logic [127:0]         rd_key_q, rd_key_d;
    logic                 rd_valid_q, rd_valid_d;

    logic                 zero_req_s, init_acc_s, we_s, rd_ok_s;
    logic [SLOT_W-1:0]    zero_slot_s;
    logic [NUM_SLOTS-1:0] clr_mask_s;
    logic [3:0]           nk_s;
    logic [5:0]           nw_s;
    logic [31:0]          step_word_s, new_word_s, wdata_s;

`ifdef AES_KEY_ZEROIZE_EN
    assign zero_req_s  = (state_q == ST_IDLE) && bus.zeroize_in;
    assign zero_slot_s = bus.zeroize_slot_in;
`else
    assign zero_req_s  = 1'b0;
    assign zero_slot_s = {SLOT_W{1'b0}};
`endif
    assign init_acc_s = (state_q == ST_IDLE) && bus.init_in && (bus.key_len_in != 2'd3) && !zero_req_s;

    // Slots invalidated this cycle; also hides them from a same-cycle read
    always_comb begin
        clr_mask_s = {NUM_SLOTS{1'b0}};
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if ((zero_req_s && (int'(zero_slot_s) == s)) || (init_acc_s && (int'(bus.init_slot_in) == s))) begin
                clr_mask_s[s] = 1'b1;
            end else begin
                clr_mask_s[s] = 1'b0;
            end
        end
    end

    assign nk_s = nk_of(len_q);
    assign nw_s = nw_of(len_q);

    aes_key_word_step u_step (
        .w_prev_i    (win_q[0]),
        .w_back_nk_i (win_q[3'(nk_s - 4'd1)]),
        .idx_i       (idx_q),
        .nk_i        (nk_s),
        .w_next_o    (step_word_s)
    );

    assign new_word_s = (idx_q < {2'b00, nk_s}) ? key_q[3'd7 - idx_q[2:0]] : step_word_s;
    assign wdata_s    = (state_q == ST_ZERO) ? 32'd0 : new_word_s;

    // FSM next state, word counter and window shift
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        slot_d       = slot_q;
        len_d        = len_q;
        key_d        = key_q;
        win_d        = win_q;
        slot_valid_d = slot_valid_q & ~clr_mask_s;
        slot_len_d   = slot_len_q;
        we_s         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (zero_req_s) begin
                    state_d = ST_ZERO;
                    slot_d  = zero_slot_s;
                    idx_d   = 6'd0;
                end else if (init_acc_s) begin
                    state_d = ST_EXPAND;
                    slot_d  = bus.init_slot_in;
                    len_d   = key_len_t'(bus.key_len_in);
                    key_d   = bus.key_in;
                    idx_d   = 6'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                we_s  = 1'b1;
                win_d = {win_q[6:0], new_word_s};
                if (idx_q == (nw_s - 6'd1)) begin
                    state_d              = ST_DONE;
                    slot_valid_d[slot_q] = 1'b1;
                    slot_len_d[slot_q]   = len_q;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ZERO: begin
                we_s = 1'b1;
                if (idx_q == 6'(MAX_WORDS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Round-key read: valid only for a completed slot and a round within its Nr
    always_comb begin
        rd_ok_s = (int'(bus.rd_slot_in) < NUM_SLOTS)
               && slot_valid_q[bus.rd_slot_in] && !clr_mask_s[bus.rd_slot_in]
               && (bus.round_rd_in <= nr_of(slot_len_q[bus.rd_slot_in]));
        rd_key_d   = 128'd0;
        rd_valid_d = 1'b0;
        if (rd_ok_s) begin
            rd_valid_d = 1'b1;
            rd_key_d   = {mem_q[bus.rd_slot_in][{bus.round_rd_in, 2'b00}],
                          mem_q[bus.rd_slot_in][{bus.round_rd_in, 2'b00} + 6'd1],
                          mem_q[bus.rd_slot_in][{bus.round_rd_in, 2'b00} + 6'd2],
                          mem_q[bus.rd_slot_in][{bus.round_rd_in, 2'b00} + 6'd3]};
        end else begin
            rd_valid_d = 1'b0;
        end
    end

    // Control, window and read-output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            idx_q        <= 6'd0;
            slot_q       <= {SLOT_W{1'b0}};
            len_q        <= KEY_128;
            key_q        <= 256'd0;
            win_q        <= 256'd0;
            slot_valid_q <= {NUM_SLOTS{1'b0}};
            slot_len_q   <= '{default: KEY_128};
            rd_key_q     <= 128'd0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            slot_q       <= slot_d;
            len_q        <= len_d;
            key_q        <= key_d;
            win_q        <= win_d;
            slot_valid_q <= slot_valid_d;
            slot_len_q   <= slot_len_d;
            rd_key_q     <= rd_key_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // Schedule storage, one word per cycle during expansion or wipe
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                for (int w = 0; w < MAX_WORDS; w++) begin
                    mem_q[s][w] <= 32'd0;
                end
            end
        end else if (we_s && (int'(slot_q) < NUM_SLOTS)) begin
            mem_q[slot_q][idx_q] <= wdata_s;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign bus.init_ready_out   = (state_q == ST_IDLE);
    assign bus.key_expanded_out = (state_q == ST_DONE);
    assign bus.key_out          = rd_key_q;
    assign bus.key_valid_out    = rd_valid_q;
    assign bus.slot_valid_out   = slot_valid_q;

endmodule

// File: tb/tb_aes_key_store.sv
// Bench for aes_key_store: FIPS-197 vectors plus random keys checked against a
// high-level KeyExpansion model built on a brute-force-inverse S-box table.
module tb_aes_key_store;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_key_store_if #(.NUM_SLOTS(NS)) bus ();
    aes_key_store #(.NUM_SLOTS(NS)) dut (.clk_in(clk), .rst_in(rst), .bus(bus.slave));

    int checks = 0;
    int errors = 0;
    logic [7:0]  sbox_t [256];
    logic [31:0] ref_w [NS][60];
    logic        ref_valid [NS];
    int          ref_nr [NS];

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        while (y != 8'h00) begin
            if (y[0]) p = p ^ x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int xv = 0; xv < 256; xv++) begin
            inv = 8'h00;
            for (int yv = 1; yv < 256; yv++)
                if (gmul(8'(xv), 8'(yv)) == 8'h01) inv = 8'(yv);
            s = 8'h63;
            for (int k = 0; k < 5; k++) s = s ^ ((inv << k) | (inv >> (8 - k)));
            sbox_t[xv] = s;
        end
    endfunction

    function automatic logic [31:0] t_sub(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [7:0] t_rcon(input int j);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 1; k < j; k++) r = gmul(r, 8'h02);
        return r;
    endfunction

    function automatic void ref_expand(input int s, input int len, input logic [255:0] key);
        int nk;
        int nw;
        logic [31:0] w [60];
        logic [31:0] t;
        nk = 4 + 2 * len;
        nw = 4 * (nk + 7);
        for (int i = 0; i < 60; i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32 * i -: 32];
            end else if (i < nw) begin
                t = w[i - 1];
                if (i % nk == 0) t = t_sub({t[23:0], t[31:24]}) ^ {t_rcon(i / nk), 24'h0};
                else if (nk == 8 && i % nk == 4) t = t_sub(t);
                w[i] = w[i - nk] ^ t;
            end else begin
                w[i] = 32'h0;
            end
            ref_w[s][i] = w[i];
        end
        ref_nr[s] = nk + 6;
    endfunction

    function automatic void exp_read(input int s, input int r, output logic ev, output logic [127:0] ek);
        ev = ref_valid[s] && (r <= ref_nr[s]);
        if (ev) ek = {ref_w[s][4 * r], ref_w[s][4 * r + 1], ref_w[s][4 * r + 2], ref_w[s][4 * r + 3]};
        else ek = 128'h0;
    endfunction

    function automatic logic [NS-1:0] ref_mask();
        logic [NS-1:0] m;
        for (int k = 0; k < NS; k++) m[k] = ref_valid[k];
        return m;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int j = 0; j < 8; j++) k[32 * j +: 32] = $urandom;
        return k;
    endfunction

    task automatic read_check(input int s, input int r, input string tag);
        logic ev;
        logic [127:0] ek;
        @(negedge clk);
        bus.rd_slot_in = 2'(s); bus.round_rd_in = 4'(r);
        @(negedge clk);
        exp_read(s, r, ev, ek);
        check({tag, " valid"}, 256'(bus.key_valid_out), 256'(ev));
        check({tag, " key"}, 256'(bus.key_out), 256'(ek));
    endtask

    task automatic read_known(input int s, input int r, input logic ev, input logic [127:0] ek, input string tag);
        @(negedge clk);
        bus.rd_slot_in = 2'(s); bus.round_rd_in = 4'(r);
        @(negedge clk);
        check({tag, " valid"}, 256'(bus.key_valid_out), 256'(ev));
        check({tag, " key"}, 256'(bus.key_out), 256'(ek));
    endtask

    // Accept an init, then watch a fixed 70-cycle window for the done pulse.
    task automatic run_expand(input int s, input int len, input logic [255:0] key,
                              input int inject_at, input bit probe, input string tag);
        int first;
        int pulses;
        int nw;
        int pr;
        logic ev;
        logic [127:0] ek;
        first = 0; pulses = 0; pr = 0;
        nw = 4 * (4 + 2 * len + 7);
        @(negedge clk);
        bus.init_in = 1'b1; bus.init_slot_in = 2'(s); bus.key_len_in = 2'(len); bus.key_in = key;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.init_in  = 1'b0;
                ref_valid[s] = 1'b0;
                check({tag, " ready drop"}, 256'(bus.init_ready_out), 256'(0));
                if (probe) check({tag, " reinit invalid"}, 256'(bus.key_valid_out), 256'(0));
            end else if (probe) begin
                exp_read(1, pr, ev, ek);
                check({tag, " slot1 valid"}, 256'(bus.key_valid_out), 256'(ev));
                check({tag, " slot1 key"}, 256'(bus.key_out), 256'(ek));
            end
            if (probe) begin
                pr = $urandom_range(0, 12);
                bus.rd_slot_in = 2'd1; bus.round_rd_in = 4'(pr);
            end
            if (inject_at != 0 && n == inject_at) begin
                bus.init_in = 1'b1; bus.init_slot_in = 2'd0; bus.key_len_in = 2'd2; bus.key_in = rand_key();
            end
            if (inject_at != 0 && n == inject_at + 1) bus.init_in = 1'b0;
            if (bus.key_expanded_out === 1'b1) begin
                pulses++;
                if (first == 0) begin
                    first = n;
                    check({tag, " slot valid at done"}, 256'(bus.slot_valid_out[s]), 256'(1));
                end
            end
        end
        check({tag, " done latency"}, 256'(first), 256'(nw + 1));
        check({tag, " done pulses"}, 256'(pulses), 256'(1));
        check({tag, " ready after"}, 256'(bus.init_ready_out), 256'(1));
        ref_expand(s, len, key);
        ref_valid[s] = 1'b1;
        check({tag, " slot mask"}, 256'(bus.slot_valid_out), 256'(ref_mask()));
    endtask

    initial begin
        int pulses;
        build_sbox();
        for (int k = 0; k < NS; k++) begin
            ref_valid[k] = 1'b0;
            ref_nr[k] = 10;
        end
        rst = 1'b1;
        bus.init_in = 1'b0; bus.init_slot_in = 2'd0; bus.key_len_in = 2'd0; bus.key_in = 256'd0;
        bus.rd_slot_in = 2'd0; bus.round_rd_in = 4'd0;
`ifdef AES_KEY_ZEROIZE_EN
        bus.zeroize_in = 1'b0; bus.zeroize_slot_in = 2'd0;
`endif
        repeat (2) @(negedge clk);
        check("reset ready", 256'(bus.init_ready_out), 256'(1));
        check("reset done", 256'(bus.key_expanded_out), 256'(0));
        check("reset valid", 256'(bus.key_valid_out), 256'(0));
        check("reset key", 256'(bus.key_out), 256'(0));
        check("reset slots", 256'(bus.slot_valid_out), 256'(0));
        rst = 1'b0;

        run_expand(0, 0, K128, 0, 1'b0, "aes128");
        read_known(0, 10, 1'b1, R128_10, "aes128 r10");
        run_expand(1, 1, K192, 0, 1'b0, "aes192");
        read_known(1, 12, 1'b1, 128'he98ba06f448c773c8ecc720401002202, "aes192 r12");
        read_known(1, 13, 1'b0, 128'h0, "aes192 r13");
        run_expand(3, 2, K256, 0, 1'b0, "aes256");
        read_known(3, 14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e, "aes256 r14");
        read_known(3, 0, 1'b1, 128'h603deb1015ca71be2b73aef0857d7781, "aes256 r0");

        for (int t = 0; t < 3; t++) begin
            run_expand(2, int'($urandom_range(0, 2)), rand_key(), 0, 1'b0, "rand");
            for (int q = 0; q < 6; q++)
                read_check(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), "rand read");
        end

        run_expand(2, 0, rand_key(), 5, 1'b0, "busy init");
        read_known(0, 10, 1'b1, R128_10, "slot0 kept");

        @(negedge clk);
        bus.init_in = 1'b1; bus.init_slot_in = 2'd0; bus.key_len_in = 2'd3; bus.key_in = rand_key();
        @(negedge clk);
        bus.init_in = 1'b0;
        check("len3 ready", 256'(bus.init_ready_out), 256'(1));
        check("len3 slots", 256'(bus.slot_valid_out), 256'(ref_mask()));
        read_known(0, 10, 1'b1, R128_10, "len3 slot0 kept");

        @(negedge clk);
        bus.rd_slot_in = 2'd0; bus.round_rd_in = 4'd10;
        @(negedge clk);
        check("pre reinit valid", 256'(bus.key_valid_out), 256'(1));
        run_expand(0, 0, rand_key(), 0, 1'b1, "reinit");
        for (int q = 0; q < 4; q++) read_check(0, int'($urandom_range(0, 11)), "reinit read");

        @(negedge clk);
        bus.init_in = 1'b1; bus.init_slot_in = 2'd2; bus.key_len_in = 2'd2; bus.key_in = rand_key();
        @(negedge clk);
        bus.init_in = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst ready", 256'(bus.init_ready_out), 256'(1));
        check("midrst done", 256'(bus.key_expanded_out), 256'(0));
        check("midrst valid", 256'(bus.key_valid_out), 256'(0));
        check("midrst key", 256'(bus.key_out), 256'(0));
        check("midrst slots", 256'(bus.slot_valid_out), 256'(0));
        rst = 1'b0;
        for (int k = 0; k < NS; k++) ref_valid[k] = 1'b0;
        pulses = 0;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            if (bus.key_expanded_out === 1'b1) pulses++;
        end
        check("midrst no pulse", 256'(pulses), 256'(0));
        for (int k = 0; k < NS; k++) read_check(k, 0, "midrst read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_store.md
Name: aes_key_store

Overview:
- Multi-slot AES round-key store. Expands AES-128, AES-192 or AES-256 cipher keys one 32-bit word per cycle, as in FIPS-197 KeyExpansion.
- Holds NUM_SLOTS independent expanded schedules and serves one 128-bit round key per cycle to the cipher datapath.
- Successor to the single-slot, 128-bit-only key memory. Sits between the key-load/control interface and the round pipeline.

Parameters:
- NUM_SLOTS, 4, number of independent key schedules held; must be at least 1.
- SLOT_W, $clog2(NUM_SLOTS) (minimum 1), slot index width; derived, not overridden.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- init_in  input  1  start expansion; accepted only when init_ready_out=1
- init_slot_in  input  SLOT_W  target slot for expansion
- key_len_in  input  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved
- key_in  input  256  cipher key; word 0 = key_in[255:224]; AES-128 uses [255:128], AES-192 uses [255:64]
- init_ready_out  output  1  high when idle and able to accept init
- key_expanded_out  output  1  one-cycle pulse when expansion completes
- rd_slot_in  input  SLOT_W  read slot
- round_rd_in  input  4  read round index, 0..14
- key_out  output  128  round key, registered
- key_valid_out  output  1  key_out is valid, registered alongside key_out
- slot_valid_out  output  NUM_SLOTS  per-slot schedule-complete flags

Behaviour:
- Reset: all storage zero, slot_valid_out=0, key_out=0, key_valid_out=0, key_expanded_out=0, init_ready_out=1, FSM=IDLE. Reset mid-expansion aborts it; no done pulse.
- Parameters per key length: Nk=4/6/8; Nr=10/12/14; Nw=4*(Nr+1)=44/52/60.
- Storage: per slot, 60 words of 32 bits. Per slot, the latched key_len is stored.
- FSM IDLE -> EXPAND -> DONE -> IDLE.
- IDLE:
  - init_in=1 with key_len_in!=3 is accepted. Latch key, key_len and slot; clear slot_valid_out[slot]; word counter i=0; go to EXPAND; init_ready_out drops next cycle.
  - key_len_in=3 is ignored; stay IDLE.
- EXPAND, one word written per cycle:
  - i<Nk: w[i] = key word i.
  - i>=Nk: w[i] = w[i-Nk] XOR f(w[i-1]).
  - f = SubWord(RotWord) XOR Rcon[i/Nk] when i mod Nk==0.
  - f = SubWord only when Nk=8 and i mod Nk==4.
  - Otherwise f = identity.
  - w[i-1] and w[i-Nk] come from a shift window of the last 8 words, not from a memory read.
  - After i=Nw-1 is written, go to DONE.
- DONE, one cycle: key_expanded_out=1, set slot_valid_out[slot], go to IDLE with init_ready_out=1.
- Latency: accept cycle T; word i written at T+1+i; done pulse at T+1+Nw (45/53/61).
- init_in while busy: ignored, with no queueing. The accepting side must wait for init_ready_out.
- Read path, 1-cycle latency. Next cycle:
  - key_out = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in [127:96].
  - key_valid_out=1 only if slot_valid_out[rd_slot_in]=1 and round_rd_in<=Nr for that slot's stored key_len.
  - Otherwise key_out=0 and key_valid_out=0.
- Reading the slot under expansion returns invalid. Reading other slots is unaffected. No read/write hazard beyond this.
- Re-initialising a valid slot invalidates it at the accept cycle.
- rd_slot_in>=NUM_SLOTS (non-power-of-two depth) reads invalid.

Optional Feature:
- Macro AES_KEY_ZEROIZE_EN.
- When defined, adds two ports:
  - zeroize_in  input  1
  - zeroize_slot_in  input  SLOT_W
- zeroize_in=1 in IDLE clears slot_valid_out[slot] and zeroes all 60 words of that slot, one word per cycle. During the clear, init_ready_out=0 and there is no done pulse. Takes 60+1 cycles.
- zeroize_in has priority over a simultaneous init_in; the init is ignored.
- zeroize_in while busy is ignored.
- Without the macro: no ports. Stale words stay in storage, hidden only by slot_valid_out.

Decomposition:
- Shared package aes_pkg:
  - key_len_t enum (KEY_128, KEY_192, KEY_256)
  - NK/NR/NW lookup functions
  - RCON table (10 entries)
  - SubWord helper using the existing S-box
  - MAX_WORDS=60
- One combinational sub-module aes_key_word_step, computing next word from w_prev, w_back_nk, i and Nk. Top level holds the FSM, window, storage and read register.

Test Plan:
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c into slot 0 -> done pulse 45 cycles after accept; round 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6, key_valid_out=1.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b into slot 1 -> done at 53 cycles; round 12 = e98ba06f448c773c8ecc720401002202; round 13 reads invalid.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 into slot 3 -> done at 61 cycles; round 14 = fe4890d1e6188d0b046df344706c631e; round 0 = 603deb1015ca71be2b73aef0857d7781.
- Second init_in while EXPAND, plus key_len_in=3 init in IDLE -> both ignored; only one done pulse; slot contents unchanged.
- Re-init slot 0 while reading it -> key_valid_out falls to 0 one cycle after accept; slot 1 reads stay valid throughout.
- rst_in asserted mid-expansion -> next cycle all outputs at reset values; no key_expanded_out; all slots read invalid.
